// File: rtl/small_poly_compress.sv
// small_poly_compress
// Converts a full polynomial of 12-bit mod-q coefficients back into the packed
// 3-bit small-polynomial encoding, LANES coefficients per cycle. Any
// coefficient without a small encoding is coded as 000. The lowest such index
// is reported through range_err / err_idx.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a polynomial; in_ready=1
// CONV  | converting group cnt_q of LANES coefficients per cycle
// DONE  | result valid; held until out_ready

`ifndef KYBER_N
`define KYBER_N 256
`endif
`ifndef KYBER_R_WIDTH
`define KYBER_R_WIDTH 12
`endif
`ifndef KYBER_SPOLY_WIDTH
`define KYBER_SPOLY_WIDTH 3
`endif
`ifndef KYBER_Q
`define KYBER_Q 3329
`endif

module small_poly_compress #(
    parameter int LANES = 16,
    parameter int IDX_W = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [`KYBER_N*`KYBER_R_WIDTH-1:0]            in_poly,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [`KYBER_N*`KYBER_SPOLY_WIDTH-1:0]        out_spoly,
    output logic                                          range_err,
    output logic [IDX_W-1:0]                              err_idx
);

    localparam int N      = `KYBER_N;
    localparam int R_W    = `KYBER_R_WIDTH;
    localparam int S_W    = `KYBER_SPOLY_WIDTH;
    localparam int Q      = `KYBER_Q;
    localparam int GROUPS = N / LANES;
    localparam int CL_W   = $clog2(N * R_W);
    localparam int SL_W   = $clog2(N * S_W);
    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(GROUPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        cnt_q, cnt_d;
    logic [N*R_W-1:0]        poly_q, poly_d;
    logic [N*S_W-1:0]        spoly_q, spoly_d;
    logic                    range_err_q, range_err_d;
    logic [IDX_W-1:0]        err_idx_q, err_idx_d;

    logic [IDX_W-1:0]        base;
    logic [CL_W-1:0]         coef_lsb;
    logic [SL_W-1:0]         code_lsb;
    logic [LANES*R_W-1:0]    grp_coef;
    logic [LANES*S_W-1:0]    grp_code;
    logic [LANES-1:0]        grp_bad;
    logic [IDX_W-1:0]        grp_first;

    // Small encoding of one coefficient; values outside the five legal ones map to 000.
    function automatic logic [S_W-1:0] code_of(input logic [R_W-1:0] v);
        logic [S_W-1:0] c;
        case (v)
            R_W'(0):     c = 3'b000;
            R_W'(1):     c = 3'b001;
            R_W'(2):     c = 3'b010;
            R_W'(Q - 1): c = 3'b111;
            R_W'(Q - 2): c = 3'b110;
            default:     c = 3'b000;
        endcase
        return c;
    endfunction

    // True when a coefficient has no small encoding.
    function automatic logic bad_of(input logic [R_W-1:0] v);
        logic b;
        case (v)
            R_W'(0), R_W'(1), R_W'(2), R_W'(Q - 1), R_W'(Q - 2): b = 1'b0;
            default:                                              b = 1'b1;
        endcase
        return b;
    endfunction

    // First coefficient index of the group being converted this cycle.
    assign base     = IDX_W'(int'(cnt_q) * LANES);
    assign coef_lsb = CL_W'(int'(base) * R_W);
    assign code_lsb = SL_W'(int'(base) * S_W);
    assign grp_coef = poly_q[coef_lsb +: LANES*R_W];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign grp_code[g*S_W +: S_W] = code_of(grp_coef[g*R_W +: R_W]);
        assign grp_bad[g]             = bad_of(grp_coef[g*R_W +: R_W]);
    end

    // Lowest out-of-range lane within the current group.
    always_comb begin
        grp_first = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (grp_bad[i]) begin
                grp_first = IDX_W'(i);
            end
        end
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        poly_d      = poly_q;
        spoly_d     = spoly_q;
        range_err_d = range_err_q;
        err_idx_d   = err_idx_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    poly_d      = in_poly;
                    cnt_d       = '0;
                    range_err_d = 1'b0;
                    err_idx_d   = '0;
                    state_d     = CONV;
                end
            end
            CONV: begin
                spoly_d[code_lsb +: LANES*S_W] = grp_code;
                // Only the first bad group records a location.
                if ((|grp_bad) && !range_err_q) begin
                    range_err_d = 1'b1;
                    err_idx_d   = base + grp_first;
                end
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            poly_q      <= '0;
            spoly_q     <= '0;
            range_err_q <= 1'b0;
            err_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            poly_q      <= poly_d;
            spoly_q     <= spoly_d;
            range_err_q <= range_err_d;
            err_idx_q   <= err_idx_d;
        end
    end

    assign out_spoly = spoly_q;
    assign range_err = range_err_q;
    assign err_idx   = err_idx_q;

endmodule

// File: doc/small_poly_compress.md
Name: small_poly_compress

Overview:
- Inverse of the small-polynomial expansion used on the adder input path. Converts a full polynomial of 12-bit mod-q coefficients back into the packed 3-bit small-polynomial encoding.
- Sits after the adder/NTT result path when a result must be stored or compared in small form, for example for the noise-poly re-check and for the compact buffer.
- Processes LANES coefficients per cycle under a valid/ready handshake on both sides.
- Flags and locates any coefficient that has no small encoding.

Parameters:
- LANES, 16, coefficients converted per cycle; must divide `KYBER_N (256). Legal values are 1, 2, 4, …, 256.
- IDX_W, 8, width of the coefficient index; equals log2(`KYBER_N).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  in_poly is valid
- in_ready  output  1  block can accept a polynomial
- in_poly  input  `KYBER_N*`KYBER_R_WIDTH (3072)  coefficient i at [i*12 +: 12]
- out_valid  output  1  out_spoly, range_err and err_idx are valid
- out_ready  input  1  consumer accepts the result
- out_spoly  output  `KYBER_N*`KYBER_SPOLY_WIDTH (768)  coefficient i at [i*3 +: 3]
- range_err  output  1  at least one coefficient was out of range
- err_idx  output  IDX_W  index of the lowest out-of-range coefficient; 0 if none

Behaviour:
- Coefficient mapping (12-bit value v → 3-bit code):
  - 0 → 000
  - 1 → 001
  - 2 → 010
  - `KYBER_Q-1 (3328) → 111
  - `KYBER_Q-2 (3327) → 110
  - Any other v, including v ≥ 3329 → 000, and the coefficient is marked out of range.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch in_poly into an internal register, clear the index counter, clear range_err, clear err_idx, and go to CONV.
  - in_poly is not sampled again until the next IDLE.
- CONV:
  - in_ready=0.
  - Each cycle convert coefficients [cnt*LANES, cnt*LANES+LANES-1] and write them into out_spoly.
  - If any coefficient in the group is bad and range_err is still 0: set range_err=1 and set err_idx to the lowest bad index in the group. Later bad coefficients do not change err_idx.
  - cnt increments every cycle. When cnt == N/LANES-1, perform that last group and go to DONE.
- DONE:
  - out_valid=1.
  - out_spoly, range_err and err_idx are held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE.
  - in_ready stays 0 in DONE; a new polynomial is accepted only from IDLE.
- Latency:
  - Handshake edge is edge 0. out_valid rises after edge N/LANES, which is 16 cycles at the default.
  - Throughput is one polynomial every N/LANES+2 cycles when out_ready is held at 1.
- Unconverted bits of out_spoly keep their previous values during CONV. Consumers must read out_spoly only while out_valid=1.
- Reset (synchronous, any state, including mid-CONV and DONE):
  - state=IDLE, cnt=0.
  - in_ready=1 on the first cycle after reset.
  - out_valid=0, out_spoly=0, range_err=0, err_idx=0.
  - Any partial conversion is discarded.
- in_valid asserted during CONV or DONE is ignored. The producer holds it until in_ready.
- out_ready asserted outside DONE has no effect.

Test Plan:
- All-zero in_poly, out_ready=1:
  - out_valid rises exactly 16 cycles after the handshake and stays high 1 cycle.
  - out_spoly=0, range_err=0, err_idx=0.
- Coefficient i = {0, 1, 2, 3328, 3327} repeated:
  - out_spoly coefficient i follows the pattern {000, 001, 010, 111, 110}; range_err=0.
- Bad values 5 at index 37 and 3329 at index 200:
  - range_err=1, err_idx=37.
  - Codes at indices 37 and 200 are 000; all other codes are correct.
- out_ready held 0 for 10 cycles in DONE:
  - out_valid stays 1 and all outputs are stable.
  - in_ready=0 throughout; a second in_valid is not accepted until one cycle after out_ready.
- rst pulsed at CONV cycle 7:
  - Next cycle out_valid=0, in_ready=1 and outputs are zero.
  - A fresh polynomial then completes with correct values.
- LANES=1 and LANES=256 builds with the mapping vector from the second scenario:
  - Latency is 256 cycles and 1 cycle respectively; results are identical.
